// File: rtl/cpu_pkg.sv
// Shared CPU constants and the call-stack controller's state and error encodings.
// Imported by the register file, the control unit and the stack controller.
package cpu_pkg;

  localparam int PC_W        = 8;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 3;
  localparam int STACK_BASE  = 7;
  localparam int STACK_DEPTH = 4;
  localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_POP_ADDR,
    ST_POP_WAIT,
    ST_DONE
  } stack_state_e;

  // Pending error reason, held from the IDLE decision until the DONE pulse.
  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_OVF,
    ERR_UNF,
    ERR_BOTH
  } stack_err_e;

endpackage

// File: rtl/stack_ptr.sv
// Stack pointer and entry counter for a downward-growing stack in the register file.
// A push moves sp down one slot, a pop moves it back up; full/empty come from depth.
module stack_ptr #(
  parameter int ADDR_W      = cpu_pkg::ADDR_W,
  parameter int STACK_BASE  = cpu_pkg::STACK_BASE,
  parameter int STACK_DEPTH = cpu_pkg::STACK_DEPTH,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  output logic [ADDR_W-1:0]  sp,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  logic [ADDR_W-1:0]  sp_q, sp_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;

  assign full  = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty = (depth_q == '0);

  // The full/empty guards keep sp inside the stack window even if a caller misbehaves.
  always_comb begin
    sp_d    = sp_q;
    depth_d = depth_q;
    if (inc && !full) begin
      sp_d    = sp_q - ADDR_W'(1);
      depth_d = depth_q + DEPTH_W'(1);
    end else if (dec && !empty) begin
      sp_d    = sp_q + ADDR_W'(1);
      depth_d = depth_q - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= ADDR_W'(STACK_BASE);
      depth_q <= '0;
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
    end
  end

  assign sp    = sp_q;
  assign depth = depth_q;

endmodule

// File: rtl/call_stack_ctrl.sv
// CALL/RET front end for the register-file stack region: turns requests into RF
// writes/reads, tracks depth, flags overflow/underflow and returns the popped PC.
module call_stack_ctrl #(
  parameter int PC_W        = cpu_pkg::PC_W,
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int ADDR_W      = cpu_pkg::ADDR_W,
  parameter int STACK_BASE  = cpu_pkg::STACK_BASE,
  parameter int STACK_DEPTH = cpu_pkg::STACK_DEPTH,
  parameter int RD_LAT      = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               call_req,
  input  logic                               ret_req,
  input  logic [PC_W-1:0]                    call_pc,
  output logic                               busy,
  output logic                               done,
  output logic [PC_W-1:0]                    ret_pc,
  output logic                               err_ovf,
  output logic                               err_unf,
  output logic                               err_both,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               rf_we,
  output logic [ADDR_W-1:0]                  rf_ws,
  output logic [DATA_W-1:0]                  rf_wd,
  output logic [ADDR_W-1:0]                  rf_rs,
  input  logic [DATA_W-1:0]                  rf_rd
);

  import cpu_pkg::*;

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int CNT_W   = 2;

  stack_state_e      state_q, state_d;
  stack_err_e        err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PC_W-1:0]   ret_pc_q, ret_pc_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_unf_q, err_unf_d;
  logic              err_both_q, err_both_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_ws_q, rf_ws_d;
  logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
  logic [ADDR_W-1:0] rf_rs_q, rf_rs_d;

  logic [ADDR_W-1:0]  sp;
  logic [DEPTH_W-1:0] sp_depth;
  logic               sp_full, sp_empty;
  logic               sp_inc, sp_dec;
  logic [PC_W-1:0]    next_pc;
  logic               unused_rd_hi;

  assign next_pc      = call_pc + PC_W'(1);
  assign unused_rd_hi = ^rf_rd;

  stack_ptr #(
    .ADDR_W      (ADDR_W),
    .STACK_BASE  (STACK_BASE),
    .STACK_DEPTH (STACK_DEPTH),
    .DEPTH_W     (DEPTH_W)
  ) u_stack_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (sp_inc),
    .dec   (sp_dec),
    .sp    (sp),
    .depth (sp_depth),
    .full  (sp_full),
    .empty (sp_empty)
  );

  // Next-state and registered-output decode; every output is a flop loaded from here.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_ovf_d  = 1'b0;
    err_unf_d  = 1'b0;
    err_both_d = 1'b0;
    ret_pc_d   = ret_pc_q;
    rf_we_d    = 1'b0;
    rf_ws_d    = rf_ws_q;
    rf_wd_d    = rf_wd_q;
    rf_rs_d    = rf_rs_q;
    sp_inc     = 1'b0;
    sp_dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (call_req && ret_req) begin
          err_d   = ERR_BOTH;
          state_d = ST_DONE;
        end else if (call_req) begin
          if (sp_full) begin
            err_d   = ERR_OVF;
            state_d = ST_DONE;
          end else begin
            state_d = ST_PUSH;
            rf_we_d = 1'b1;
            rf_ws_d = sp;
            rf_wd_d = DATA_W'(next_pc);
          end
        end else if (ret_req) begin
          if (sp_empty) begin
            err_d   = ERR_UNF;
            state_d = ST_DONE;
          end else begin
            state_d = ST_POP_ADDR;
            rf_rs_d = sp + ADDR_W'(1);
            cnt_d   = CNT_W'(RD_LAT);
          end
        end
      end

      // The RF commits the write on the edge that leaves PUSH, so sp/depth move there too.
      ST_PUSH: begin
        sp_inc  = 1'b1;
        state_d = ST_DONE;
      end

      ST_POP_ADDR, ST_POP_WAIT: begin
        if (cnt_q == '0) begin
          ret_pc_d = rf_rd[PC_W-1:0];
          sp_dec   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = ST_POP_WAIT;
        end
      end

      ST_DONE: begin
        done_d     = 1'b1;
        err_ovf_d  = (err_q == ERR_OVF);
        err_unf_d  = (err_q == ERR_UNF);
        err_both_d = (err_q == ERR_BOTH);
        err_d      = ERR_NONE;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Reset drops any operation in flight; a write already taken by the RF is simply forgotten.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      err_q      <= ERR_NONE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ret_pc_q   <= '0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
      err_both_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_ws_q    <= '0;
      rf_wd_q    <= '0;
      rf_rs_q    <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ret_pc_q   <= ret_pc_d;
      err_ovf_q  <= err_ovf_d;
      err_unf_q  <= err_unf_d;
      err_both_q <= err_both_d;
      rf_we_q    <= rf_we_d;
      rf_ws_q    <= rf_ws_d;
      rf_wd_q    <= rf_wd_d;
      rf_rs_q    <= rf_rs_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ret_pc   = ret_pc_q;
  assign err_ovf  = err_ovf_q;
  assign err_unf  = err_unf_q;
  assign err_both = err_both_q;
  assign depth    = sp_depth;
  assign rf_we    = rf_we_q;
  assign rf_ws    = rf_ws_q;
  assign rf_wd    = rf_wd_q;
  assign rf_rs    = rf_rs_q;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Bench for call_stack_ctrl: two instances (read latency 1 and 3) against a
// register-file model and an array-based stack reference, directed then random.
module tb_call_stack_ctrl;
  import cpu_pkg::*;

  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset    [2];
  logic              call_req [2];
  logic              ret_req  [2];
  logic [PC_W-1:0]   call_pc  [2];
  logic              busy     [2];
  logic              done     [2];
  logic [PC_W-1:0]   ret_pc   [2];
  logic              err_ovf  [2];
  logic              err_unf  [2];
  logic              err_both [2];
  logic [DW-1:0]     depth    [2];
  logic              rf_we    [2];
  logic [ADDR_W-1:0] rf_ws    [2];
  logic [DATA_W-1:0] rf_wd    [2];
  logic [ADDR_W-1:0] rf_rs    [2];
  logic [DATA_W-1:0] rf_rd    [2];

  int checks   = 0;
  int failures = 0;
  int we_cnt   [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};

  // Reference: return addresses as a plain array indexed by entry count, plus last popped PC.
  logic [PC_W-1:0] m_stack [2][STACK_DEPTH];
  int              m_depth [2];
  logic [PC_W-1:0] m_ret   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [DATA_W-1:0] mem  [2**ADDR_W];
    logic [DATA_W-1:0] pipe [LAT];

    call_stack_ctrl #(.RD_LAT(LAT)) u_dut (
      .clk      (clk),
      .reset    (reset[g]),
      .call_req (call_req[g]),
      .ret_req  (ret_req[g]),
      .call_pc  (call_pc[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .ret_pc   (ret_pc[g]),
      .err_ovf  (err_ovf[g]),
      .err_unf  (err_unf[g]),
      .err_both (err_both[g]),
      .depth    (depth[g]),
      .rf_we    (rf_we[g]),
      .rf_ws    (rf_ws[g]),
      .rf_wd    (rf_wd[g]),
      .rf_rs    (rf_rs[g]),
      .rf_rd    (rf_rd[g])
    );

    // Register file with a LAT-deep read pipeline; contents start as random junk.
    initial begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= $urandom;
      for (int i = 0; i < LAT; i++) pipe[i] <= $urandom;
      forever begin
        @(posedge clk);
        if (rf_we[g]) mem[rf_ws[g]] <= rf_wd[g];
        pipe[0] <= mem[rf_rs[g]];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign rf_rd[g] = pipe[LAT-1];
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rf_we[d]) we_cnt[d]++;
      if (done[d]) done_cnt[d]++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int latOf(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyReset(input int d);
    @(negedge clk);
    reset[d] = 1'b1;
    @(negedge clk);
    checkOutput($sformatf("d%0d_rst_busy", d), busy[d], 0);
    checkOutput($sformatf("d%0d_rst_done", d), done[d], 0);
    checkOutput($sformatf("d%0d_rst_depth", d), depth[d], 0);
    checkOutput($sformatf("d%0d_rst_we", d), rf_we[d], 0);
    checkOutput($sformatf("d%0d_rst_retpc", d), ret_pc[d], 0);
    checkOutput($sformatf("d%0d_rst_errs", d), {err_ovf[d], err_unf[d], err_both[d]}, 0);
    reset[d]  = 1'b0;
    m_depth[d] = 0;
    m_ret[d]   = '0;
  endtask

  // kind: 0 = CALL, 1 = RET, 2 = both at once. inject raises call_req while busy.
  task automatic applyStimulus(input int d, input int kind, input logic [PC_W-1:0] pc, input bit inject);
    bit              is_push, is_pop, is_ovf, is_unf, is_both, rs_ok;
    int              lat, lat_exp, we0, dn0;
    logic [ADDR_W-1:0] exp_slot;
    logic [PC_W-1:0] exp_ret;
    is_both = (kind == 2);
    is_push = (kind == 0) && (m_depth[d] < STACK_DEPTH);
    is_ovf  = (kind == 0) && (m_depth[d] == STACK_DEPTH);
    is_pop  = (kind == 1) && (m_depth[d] > 0);
    is_unf  = (kind == 1) && (m_depth[d] == 0);
    lat_exp = is_push ? 2 : (is_pop ? 2 + latOf(d) : 1);
    exp_slot = ADDR_W'(STACK_BASE - m_depth[d] + (is_pop ? 1 : 0));
    exp_ret  = is_pop ? m_stack[d][m_depth[d]-1] : m_ret[d];
    we0 = we_cnt[d];
    dn0 = done_cnt[d];
    rs_ok = 1'b1;
    lat = -1;

    @(negedge clk);
    call_req[d] = (kind != 1);
    ret_req[d]  = (kind != 0);
    call_pc[d]  = pc;
    @(posedge clk);
    #1;
    call_req[d] = 1'b0;
    ret_req[d]  = 1'b0;

    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checkOutput($sformatf("d%0d_busy_start", d), busy[d], 1);
        checkOutput($sformatf("d%0d_we_start", d), rf_we[d], is_push);
        if (is_push) begin
          checkOutput($sformatf("d%0d_ws", d), rf_ws[d], exp_slot);
          checkOutput($sformatf("d%0d_wd", d), rf_wd[d], DATA_W'(PC_W'(pc + 1)));
        end
        if (is_pop) checkOutput($sformatf("d%0d_rs", d), rf_rs[d], exp_slot);
        if (inject) begin
          call_req[d] = 1'b1;
          call_pc[d]  = PC_W'($urandom);
        end
      end
      if (done[d]) begin
        lat = k;
        break;
      end
      if (is_pop && rf_rs[d] !== exp_slot) rs_ok = 1'b0;
    end
    call_req[d] = 1'b0;

    if (is_push) begin
      m_stack[d][m_depth[d]] = PC_W'(pc + 1);
      m_depth[d]++;
    end
    if (is_pop) begin
      m_depth[d]--;
      m_ret[d] = exp_ret;
    end

    checkOutput($sformatf("d%0d_latency", d), lat, lat_exp);
    checkOutput($sformatf("d%0d_err_ovf", d), err_ovf[d], is_ovf);
    checkOutput($sformatf("d%0d_err_unf", d), err_unf[d], is_unf);
    checkOutput($sformatf("d%0d_err_both", d), err_both[d], is_both);
    checkOutput($sformatf("d%0d_ret_pc", d), ret_pc[d], exp_ret);
    checkOutput($sformatf("d%0d_depth", d), depth[d], m_depth[d]);
    checkOutput($sformatf("d%0d_busy_done", d), busy[d], 0);
    if (is_pop) checkOutput($sformatf("d%0d_rs_stable", d), rs_ok, 1);

    @(negedge clk);
    checkOutput($sformatf("d%0d_done_pulse", d), done[d], 0);
    checkOutput($sformatf("d%0d_err_pulse", d), {err_ovf[d], err_unf[d], err_both[d]}, 0);
    checkOutput($sformatf("d%0d_we_count", d), we_cnt[d] - we0, is_push);
    checkOutput($sformatf("d%0d_done_count", d), done_cnt[d] - dn0, 1);
  endtask

  // Abort a pop in its wait phase; the instance must come back idle and empty with no done.
  task automatic resetDuringPop(input int d);
    int dn0;
    dn0 = done_cnt[d];
    @(negedge clk);
    ret_req[d] = 1'b1;
    @(posedge clk);
    #1;
    ret_req[d] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput($sformatf("d%0d_abort_busy_pre", d), busy[d], 1);
    reset[d] = 1'b1;
    @(negedge clk);
    reset[d] = 1'b0;
    m_depth[d] = 0;
    m_ret[d]   = '0;
    checkOutput($sformatf("d%0d_abort_busy", d), busy[d], 0);
    checkOutput($sformatf("d%0d_abort_depth", d), depth[d], 0);
    repeat (6) @(negedge clk);
    checkOutput($sformatf("d%0d_abort_done", d), done_cnt[d] - dn0, 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d]    = 1'b1;
      call_req[d] = 1'b0;
      ret_req[d]  = 1'b0;
      call_pc[d]  = '0;
      m_depth[d]  = 0;
      m_ret[d]    = '0;
    end
    repeat (2) @(negedge clk);
    applyReset(0);
    applyReset(1);

    applyStimulus(0, 0, 8'h10, 1'b0);
    applyStimulus(0, 0, 8'h20, 1'b0);
    applyStimulus(0, 0, 8'h30, 1'b0);
    applyStimulus(0, 1, 8'h00, 1'b0);
    applyStimulus(0, 1, 8'h00, 1'b0);
    applyStimulus(0, 1, 8'h00, 1'b0);

    for (int i = 0; i < 4; i++) applyStimulus(0, 0, PC_W'($urandom), 1'b0);
    applyStimulus(0, 0, 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'h00, 1'b0);
    applyStimulus(0, 1, 8'h00, 1'b0);
    applyReset(0);
    applyStimulus(0, 1, 8'h00, 1'b0);

    applyStimulus(0, 0, 8'hFF, 1'b0);
    applyStimulus(0, 2, 8'h44, 1'b0);
    applyStimulus(0, 0, 8'h7A, 1'b0);
    applyStimulus(0, 1, 8'h00, 1'b1);
    applyStimulus(0, 1, 8'h00, 1'b0);

    applyStimulus(1, 0, 8'h3C, 1'b0);
    applyStimulus(1, 0, 8'h81, 1'b0);
    applyStimulus(1, 1, 8'h00, 1'b0);
    resetDuringPop(1);
    applyStimulus(1, 1, 8'h00, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int d, r, kind;
      d = (i % 3 == 2) ? 1 : 0;
      r = $urandom_range(0, 9);
      kind = (r < 5) ? 0 : ((r < 9) ? 1 : 2);
      applyStimulus(d, kind, PC_W'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
